// File: rtl/chroma_upsample_stream_if.sv
// Block-stream bundle for chroma_upsample_stream: input block handshake plus
// expanded output stream. The slave side is the upsampler, the master side the host.
interface chroma_upsample_stream_if #(
  parameter int DATA_W = 9,
  parameter int CH_W   = 2
);
  logic [1:0]                     cfg_mode;
  logic                           in_valid;
  logic                           in_ready;
  logic [CH_W-1:0]                in_ch;
  logic [7:0][7:0][DATA_W-1:0]    in_block;
  logic                           out_valid;
  logic                           out_ready;
  logic [7:0][7:0][DATA_W-1:0]    out_block;
  logic [CH_W-1:0]                out_ch;
  logic [1:0]                     out_idx;
  logic                           out_last;
  logic                           drop_err;

  modport slave (
    input  cfg_mode, in_valid, in_ch, in_block, out_ready,
    output in_ready, out_valid, out_block, out_ch, out_idx, out_last, drop_err
  );

  modport master (
    output cfg_mode, in_valid, in_ch, in_block, out_ready,
    input  in_ready, out_valid, out_block, out_ch, out_idx, out_last, drop_err
  );
endinterface

// File: rtl/chroma_upsample_stream.sv
// Expands one 8x8 chroma block into 1/2/4 full-resolution blocks (luma passes through).
// Define CHROMA_INTERP_EN to linearly interpolate odd output columns of 4:2:2/4:2:0 chroma.
module chroma_upsample_stream #(
  parameter int DATA_W = 9,
  parameter int NUM_CH = 3,
  parameter int CH_W   = $clog2(NUM_CH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  chroma_upsample_stream_if.slave bus
);
  typedef logic [7:0][7:0][DATA_W-1:0] blk_t;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  logic [0:0]      state;
  blk_t            blk_q;
  logic [1:0]      exp_q;      // 0 = pass, 1 = horizontal x2, 2 = horizontal+vertical x2
  logic [1:0]      last_q;
  logic            out_valid_q;
  blk_t            out_block_q;
  logic [CH_W-1:0] out_ch_q;
  logic [1:0]      out_idx_q;
  logic            out_last_q;
  logic            drop_q;

  logic [1:0]      exp_in;
  logic [1:0]      sel_exp;
  logic [1:0]      sel_idx;
  logic [1:0]      sel_last;
  blk_t            sel_src;
  blk_t            map_blk;
  logic            bad_ch;

  always_comb begin
    exp_in = 2'd0;
    if (bus.in_ch != '0 && (bus.cfg_mode == 2'd1 || bus.cfg_mode == 2'd2))
      exp_in = bus.cfg_mode;
  end

  assign bad_ch   = bus.in_ch >= CH_W'(NUM_CH);
  assign sel_src  = (state == IDLE) ? bus.in_block : blk_q;
  assign sel_exp  = (state == IDLE) ? exp_in : exp_q;
  assign sel_idx  = (state == IDLE) ? 2'd0 : out_idx_q + 2'd1;
  assign sel_last = (sel_exp == 2'd2) ? 2'd3 : (sel_exp == 2'd1) ? 2'd1 : 2'd0;

  // One shared mapper: fed from the live input when entering EMIT, else from the capture.
  always_comb begin
    logic [2:0] iv, jv, ri, ci;
`ifdef CHROMA_INTERP_EN
    logic [2:0]    c1i;
    logic [DATA_W:0] sum;
`endif
    map_blk = '0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        iv = 3'(i);
        jv = 3'(j);
        ri = (sel_exp == 2'd2) ? {sel_idx[1], iv[2:1]} : iv;
        ci = (sel_exp != 2'd0) ? {sel_idx[0], jv[2:1]} : jv;
`ifdef CHROMA_INTERP_EN
        c1i = (ci == 3'd7) ? 3'd7 : ci + 3'd1;
        sum = {1'b0, sel_src[ri][ci]} + {1'b0, sel_src[ri][c1i]} + (DATA_W+1)'(1);
        if (sel_exp != 2'd0 && jv[0])
          map_blk[i][j] = sum[DATA_W:1];
        else
          map_blk[i][j] = sel_src[ri][ci];
`else
        map_blk[i][j] = sel_src[ri][ci];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      blk_q       <= '0;
      exp_q       <= 2'd0;
      last_q      <= 2'd0;
      out_valid_q <= 1'b0;
      out_block_q <= '0;
      out_ch_q    <= '0;
      out_idx_q   <= 2'd0;
      out_last_q  <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (bad_ch) begin
              drop_q <= 1'b1;
            end else begin
              blk_q       <= bus.in_block;
              exp_q       <= exp_in;
              last_q      <= sel_last;
              out_valid_q <= 1'b1;
              out_block_q <= map_blk;
              out_ch_q    <= bus.in_ch;
              out_idx_q   <= 2'd0;
              out_last_q  <= (sel_last == 2'd0);
              state       <= EMIT;
            end
          end
        end
        default: begin
          if (bus.out_ready) begin
            if (out_last_q) begin
              out_valid_q <= 1'b0;
              state       <= IDLE;
            end else begin
              out_idx_q   <= sel_idx;
              out_last_q  <= (sel_idx == last_q);
              out_block_q <= map_blk;
            end
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.out_block = out_block_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_last  = out_last_q;
  assign bus.drop_err  = drop_q;
endmodule

// File: tb/tb_chroma_upsample_stream.sv
// Directed bench for chroma_upsample_stream: luma, 4:2:0, 4:2:2 with stall, drop, reset, interpolation.
module tb_chroma_upsample_stream;
  localparam int DATA_W = 9;
  localparam int NUM_CH = 3;
  localparam int CH_W   = 2;
  typedef logic [7:0][7:0][DATA_W-1:0] blk_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  blk_t ramp, held;

  always #5 clk = ~clk;

  chroma_upsample_stream_if #(.DATA_W(DATA_W), .CH_W(CH_W)) bus ();

  chroma_upsample_stream #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [575:0] obs, input logic [575:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected output for the 8*r+c ramp input; mode_exp 0 pass, 1 H, 2 H+V.
  function automatic blk_t exp_ramp(int mode_exp, int qr, int qc);
    blk_t b;
    int r, c;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        r = (mode_exp == 2) ? 4*qr + i/2 : i;
        c = (mode_exp > 0) ? 4*qc + j/2 : j;
`ifdef CHROMA_INTERP_EN
        // neighbours on the ramp differ by 1, so the rounded average is the right neighbour
        if (mode_exp > 0 && (j % 2) == 1) c = (c < 7) ? c + 1 : 7;
`endif
        b[i][j] = DATA_W'(8*r + c);
      end
    return b;
  endfunction

  initial begin
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        ramp[i][j] = DATA_W'(8*i + j);
    bus.cfg_mode  = 2'd0;
    bus.in_valid  = 1'b0;
    bus.in_ch     = '0;
    bus.in_block  = '0;
    bus.out_ready = 1'b1;

    // reset state
    tick(); tick();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_block", bus.out_block, 0);
    chk("rst_out_ch_idx_last", {bus.out_ch, bus.out_idx, bus.out_last}, 0);
    chk("rst_drop", bus.drop_err, 0);
    rst = 1'b0;
    #1 chk("post_rst_in_ready", bus.in_ready, 1);

    // luma pass-through
    bus.in_valid = 1'b1; bus.in_ch = 2'd0; bus.cfg_mode = 2'd2; bus.in_block = ramp;
    tick();
    bus.in_valid = 1'b0;
    chk("luma_valid", bus.out_valid, 1);
    chk("luma_idx_last", {bus.out_idx, bus.out_last}, 3'b001);
    chk("luma_block", bus.out_block, ramp);
    chk("luma_in_ready_busy", bus.in_ready, 0);
    tick();
    chk("luma_done_valid", bus.out_valid, 0);
    chk("luma_done_in_ready", bus.in_ready, 1);

    // 4:2:0 chroma
    bus.in_valid = 1'b1; bus.in_ch = 2'd1; bus.cfg_mode = 2'd2;
    tick();
    bus.in_valid = 1'b0;
    for (int q = 0; q < 4; q++) begin
      chk($sformatf("c420_valid_%0d", q), bus.out_valid, 1);
      chk($sformatf("c420_idx_%0d", q), bus.out_idx, q);
      chk($sformatf("c420_last_%0d", q), bus.out_last, (q == 3));
      chk($sformatf("c420_ch_%0d", q), bus.out_ch, 1);
      chk($sformatf("c420_block_%0d", q), bus.out_block, exp_ramp(2, q/2, q%2));
      if (q == 3) begin
        chk("c420_q3_00", bus.out_block[0][0], 36);
        chk("c420_q3_77", bus.out_block[7][7], 63);
      end
      tick();
    end
    chk("c420_done_valid", bus.out_valid, 0);

    // 4:2:2 with backpressure on beat 0
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_ch = 2'd2; bus.cfg_mode = 2'd1;
    tick();
    bus.in_valid = 1'b0;
    chk("c422_b0_block", bus.out_block, exp_ramp(1, 0, 0));
    held = bus.out_block;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("c422_hold_valid_%0d", k), bus.out_valid, 1);
      chk($sformatf("c422_hold_idx_last_%0d", k), {bus.out_ch, bus.out_idx, bus.out_last}, {2'd2, 2'd0, 1'b0});
      chk($sformatf("c422_hold_block_%0d", k), bus.out_block, exp_ramp(1, 0, 0));
    end
    bus.out_ready = 1'b1;
    tick();
    chk("c422_b1_idx_last", {bus.out_idx, bus.out_last}, 3'b011);
    chk("c422_b1_50", bus.out_block[5][0], 44);
    chk("c422_b1_block", bus.out_block, exp_ramp(1, 0, 1));
    tick();
    chk("c422_done_valid", bus.out_valid, 0);

    // bad channel dropped
    bus.in_valid = 1'b1; bus.in_ch = 2'd3;
    tick();
    bus.in_valid = 1'b0;
    chk("drop_pulse", bus.drop_err, 1);
    chk("drop_no_valid", bus.out_valid, 0);
    chk("drop_in_ready", bus.in_ready, 1);
    tick();
    chk("drop_pulse_end", bus.drop_err, 0);
    chk("drop_still_no_valid", bus.out_valid, 0);

    // reset in the middle of a 4:2:0 block
    bus.in_valid = 1'b1; bus.in_ch = 2'd1; bus.cfg_mode = 2'd2;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("mid_idx1", bus.out_idx, 1);
    rst = 1'b1;
    #1 chk("mid_rst_in_ready", bus.in_ready, 0);
    tick();
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_block", bus.out_block, 0);
    chk("mid_rst_ch_idx_last", {bus.out_ch, bus.out_idx, bus.out_last}, 0);
    rst = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("mid_new_valid_idx", {bus.out_valid, bus.out_idx}, 3'b100);
    chk("mid_new_block", bus.out_block, exp_ramp(2, 0, 0));
    for (int k = 0; k < 4; k++) tick();
    chk("mid_new_done", {bus.out_valid, bus.in_ready}, 2'b01);

    // row 0 = 10..80, chroma 4:2:2
    held = '0;
    for (int j = 0; j < 8; j++) held[0][j] = DATA_W'(10*(j+1));
    bus.in_block = held; bus.in_valid = 1'b1; bus.in_ch = 2'd1; bus.cfg_mode = 2'd1;
    tick();
    bus.in_valid = 1'b0;
`ifdef CHROMA_INTERP_EN
    chk("interp_row0_0_3", {bus.out_block[0][0], bus.out_block[0][1], bus.out_block[0][2], bus.out_block[0][3]},
        {9'd10, 9'd15, 9'd20, 9'd25});
`else
    chk("nn_row0_0_3", {bus.out_block[0][0], bus.out_block[0][1], bus.out_block[0][2], bus.out_block[0][3]},
        {9'd10, 9'd10, 9'd20, 9'd20});
`endif
    tick();
    chk("edge_idx1", bus.out_idx, 1);
    chk("edge_row0_7", bus.out_block[0][7], 80);
    tick();
    chk("edge_done", bus.out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
